// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage between program_counter and decode.
// Issues one instruction-memory read per PC value, queues {pc, instr} pairs
// in a DEPTH-entry FIFO and presents the head to decode over valid/ready.
// pc_en tells program_counter to advance (fetch retired) or load (flush).
// Optional feature macro: IFB_BYPASS_EN - when defined, an acked fetch into an
// empty FIFO is presented to decode in the same cycle and skips the FIFO if
// decode takes it immediately.
module instr_fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int ILEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [XLEN-1:0]          pc,
   output logic                     pc_en,
   input  logic                     flush,
   output logic                     imem_req,
   output logic [XLEN-1:0]          imem_addr,
   input  logic                     imem_ack,
   input  logic [ILEN-1:0]          imem_rdata,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [XLEN-1:0]          id_pc,
   output logic [ILEN-1:0]          id_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              issue;
   logic              fetch_done;
   logic              push, pop, byp_take;
   logic [CW-1:0]     cnt_q;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   pc_mem    [DEPTH];
   logic [ILEN-1:0]   instr_mem [DEPTH];

   // Byte-offset bits of pc are dropped: fetch addresses are word aligned.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^pc[1:0];

   // State register; reset abandons any outstanding read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: one outstanding read; a flushed read must still be waited out.
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      fetch_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!flush && (cnt_q < FULL_CNT)) begin
               issue   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_ack) begin
               state_d    = S_IDLE;
               fetch_done = !flush;
            end else if (flush) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req  = (state_q != S_IDLE);
   assign imem_addr = addr_q;
   assign pc_en     = flush | fetch_done;

   // Fetch address is captured at issue and held for the whole request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        addr_q <= '0;
      else if (issue) addr_q <= {pc[XLEN-1:2], 2'b00};
   end

`ifdef IFB_BYPASS_EN
   logic byp_fire;
   assign byp_fire = fetch_done && (cnt_q == '0);
   assign byp_take = byp_fire && id_ready;
   assign id_valid = (cnt_q != '0) || byp_fire;
   assign id_pc    = (cnt_q != '0) ? pc_mem[rd_ptr]    : (byp_fire ? addr_q     : '0);
   assign id_instr = (cnt_q != '0) ? instr_mem[rd_ptr] : (byp_fire ? imem_rdata : '0);
`else
   assign byp_take = 1'b0;
   assign id_valid = (cnt_q != '0);
   assign id_pc    = id_valid ? pc_mem[rd_ptr]    : '0;
   assign id_instr = id_valid ? instr_mem[rd_ptr] : '0;
`endif

   // Flush wins over a same-cycle pop; a bypassed fetch never enters the FIFO.
   assign push = fetch_done && !byp_take;
   assign pop  = (cnt_q != '0) && id_ready && !flush;

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // FIFO storage: data only, contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= addr_q;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

   assign count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: randomized scoreboard bench for instr_fetch_buffer.
// The bench plays program_counter and instruction memory; every fetch that
// retires pushes its expected {pc, instr} into a queue, and a monitor pops and
// compares whenever decode accepts an entry. A flush empties the queue.
module tb_instr_fetch_buffer;

   localparam int DEPTH  = 4;
   localparam int XLEN   = 32;
   localparam int ILEN   = 32;
   localparam int NCYC   = 3000;

   logic              clk = 1'b0;
   logic              rst;
   logic [XLEN-1:0]   pc;
   logic              pc_en;
   logic              flush;
   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic              imem_ack;
   logic [ILEN-1:0]   imem_rdata;
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_pc;
   logic [ILEN-1:0]   id_instr;
   logic [2:0]        count;

   instr_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_en      (pc_en),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_pc      (id_pc),
      .id_instr   (id_instr),
      .count      (count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int full_hits = 0;
   bit mon_en = 1'b0;
   bit pushed_now = 1'b0;

   typedef struct {
      logic [XLEN-1:0] epc;
      logic [ILEN-1:0] einstr;
   } entry_t;
   entry_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Memory contents: a fixed function of the word address.
   function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F13;
   endfunction

   // Stimulus: program counter, instruction memory, flushes and decode readiness.
   initial begin
      bit              outstanding = 1'b0;
      bit              poisoned = 1'b0;
      int unsigned     lat = 0;
      bit              pc_en_prev = 1'b0;
      bit              flush_prev = 1'b0;
      logic [XLEN-1:0] tgt = '0;
      logic [XLEN-1:0] tgt_prev = '0;
      int              rdy_pct, fl_pct;

      rst = 1'b1; pc = '0; flush = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; id_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_imem_req",  imem_req,  0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_id_valid",  id_valid,  0);
      chk("rst_id_pc",     id_pc,     0);
      chk("rst_id_instr",  id_instr,  0);
      chk("rst_pc_en",     pc_en,     0);
      chk("rst_count",     count,     0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc < 1000)      begin rdy_pct = 70; fl_pct = 5;  end
         else if (cyc < 1400) begin rdy_pct = 0;  fl_pct = 0;  end
         else if (cyc < 1600) begin rdy_pct = 10; fl_pct = 0;  end
         else                 begin rdy_pct = 50; fl_pct = 10; end

         // program_counter: load target on flush, otherwise step one word.
         if (pc_en_prev) pc = flush_prev ? tgt_prev : pc + 32'd4;

         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         pushed_now = 1'b0;
         if (imem_req) begin
            if (!outstanding) begin
               outstanding = 1'b1;
               poisoned    = 1'b0;
               lat         = $urandom_range(0, 3);
            end
            if (lat == 0) imem_ack = 1'b1;
            else          lat--;
         end

         flush = ($urandom_range(0, 99) < fl_pct);
         tgt   = {$urandom_range(0, 16'hFFFF), 2'b00};
         if (flush && outstanding) poisoned = 1'b1;

         if (imem_ack) begin
            imem_rdata  = mem_word(imem_addr);
            outstanding = 1'b0;
            if (!poisoned && !flush) begin
               exp_q.push_back('{epc: imem_addr, einstr: imem_rdata});
               pushed_now = 1'b1;
            end
         end

         id_ready = ($urandom_range(0, 99) < rdy_pct);

         @(negedge clk);
         pc_en_prev = pc_en;
         flush_prev = flush;
         tgt_prev   = tgt;
         @(posedge clk); #1;
      end

      mon_en = 1'b0;
      checks++;
      if (full_hits == 0) begin
         errors++;
         $display("FAIL fifo_full_reached actual=%0d required=>0", full_hits);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Monitor: compares occupancy, handshakes and popped entries against the queue.
   initial begin
      bit              req_prev = 1'b0;
      logic [XLEN-1:0] addr_hold = '0;
      int              exp_cnt;
      bit              exp_valid;
      entry_t          e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            exp_cnt = exp_q.size() - (pushed_now ? 1 : 0);
`ifdef IFB_BYPASS_EN
            exp_valid = (exp_q.size() != 0);
`else
            exp_valid = (exp_cnt != 0);
`endif
            chk("count",    count,    exp_cnt);
            chk("id_valid", id_valid, exp_valid);
            chk("pc_en",    pc_en,    (flush || pushed_now));
            if (exp_cnt == DEPTH) begin
               full_hits++;
               chk("no_req_when_full", imem_req, 0);
            end
            if (imem_req && !req_prev)
               chk("issue_addr", imem_addr, {pc[XLEN-1:2], 2'b00});
            else if (imem_req)
               chk("addr_hold", imem_addr, addr_hold);
            addr_hold = imem_addr;
            req_prev  = imem_req;

            if (flush) begin
               exp_q.delete();
            end else if (id_valid && id_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pop actual=%0h required=none", id_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("id_pc",    id_pc,    e.epc);
                  chk("id_instr", id_instr, e.einstr);
               end
            end
         end
      end
   end

endmodule
